// File: rtl/key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl -- AES-128 key expansion controller.
//
// Accepts a 128-bit cipher key, stores it as round key 0, then derives one
// full round key per cycle until all eleven round keys (0..10) are held in
// local storage. Each round key can be read combinationally by index once
// its availability bit is set.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   key_valid  in   cipher key offered
//   key[127:0] in   AES-128 cipher key, byte 0 = key[127:120]
//   key_ready  out  controller can accept a key (IDLE or READY)
//   flush      in   synchronous abort; invalidates every round key
//   rk_idx     in   round-key read index (0..10; 11..15 read as zero)
//   rk_out     out  selected round key, zero unless valid
//   rk_avail   out  bit r set when round key r is stored and valid
//   busy       out  expansion in progress
//   done       out  one-cycle pulse after round key 10 is stored
//
// Build option
//   KS_ZEROIZE_EN  when defined, round-key storage is cleared to zero on
//                  rst, on flush and on every key accept. Port behaviour is
//                  unchanged because rk_avail gates every read.
// ---------------------------------------------------------------------------
module key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         flush,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic [10:0]  rk_avail,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Four byte lookups in parallel -- one S-box per byte lane.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [10:0]    avail_q, avail_d;
  logic           done_q, done_d;

  logic [127:0]   rk_mem [0:10];
  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_data;
  logic           accept;

  logic [3:0]     prev_idx;
  logic [127:0]   prev_rk;
  logic [31:0]    w0, w1, w2, w3, t, nw0, nw1, nw2, nw3;
  logic [3:0]     rd_idx;
  logic           rd_ok;

  // Round-key derivation from the previously stored key (index rnd_q-1).
  always_comb begin
    prev_idx = rnd_q - 4'd1;
    prev_rk  = '0;
    if (rnd_q >= 4'd1 && rnd_q <= 4'd10) prev_rk = rk_mem[prev_idx];
    {w0, w1, w2, w3} = prev_rk;
    t   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_q), 24'h0};
    nw0 = w0 ^ t;
    nw1 = w1 ^ nw0;
    nw2 = w2 ^ nw1;
    nw3 = w3 ^ nw2;
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    avail_d = avail_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = 4'd0;
    wr_data = key;
    accept  = 1'b0;
    if (flush) begin
      // Flush beats a simultaneous key offer and any pending done.
      state_d = IDLE;
      rnd_d   = 4'd0;
      avail_d = '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (key_valid) begin
            accept  = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = 4'd0;
            wr_data = key;
            avail_d = 11'b1;
            rnd_d   = 4'd1;
            state_d = EXPAND;
          end
        end
        EXPAND: begin
          wr_en   = 1'b1;
          wr_idx  = rnd_q;
          wr_data = {nw0, nw1, nw2, nw3};
          avail_d = avail_q | (11'd1 << rnd_q);
          if (rnd_q == 4'd10) begin
            // Counter parks at 10 in READY rather than wrapping.
            state_d = READY;
            done_d  = 1'b1;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          rnd_d   = 4'd0;
          avail_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      avail_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      avail_q <= avail_d;
      done_q  <= done_d;
    end
  end

  // Storage carries no reset: rk_avail gates every read.
`ifdef KS_ZEROIZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) rk_mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i <= 10; i++) rk_mem[i] <= '0;
    end else begin
      // Clear first so the round-key-0 write below takes precedence.
      if (accept) begin
        for (int i = 0; i <= 10; i++) rk_mem[i] <= '0;
      end
      if (wr_en) rk_mem[wr_idx] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) rk_mem[wr_idx] <= wr_data;
  end
`endif

  // Out-of-range indices are clamped for the array read, then masked.
  always_comb begin
    rd_idx = (rk_idx <= 4'd10) ? rk_idx : 4'd0;
    rd_ok  = (rk_idx <= 4'd10) && avail_q[rd_idx];
    rk_out = rd_ok ? rk_mem[rd_idx] : '0;
  end

  assign key_ready = (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);
  assign done      = done_q;
  assign rk_avail  = avail_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
module tb_key_sched_ctrl;

  typedef logic [10:0][127:0] sched_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key;
  logic         key_ready;
  logic         flush;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic [10:0]  rk_avail;
  logic         busy;
  logic         done;

  logic [3:0]   stim_idx;
  logic [3:0]   mon_idx;
  logic         mon_act = 1'b0;

  int errors = 0;
  int checks = 0;

  sched_t       sbq[$];
  logic [7:0]   sb [0:255];

  assign rk_idx = mon_act ? mon_idx : stim_idx;

  always #20 clk = ~clk;

  key_sched_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .key_ready(key_ready), .flush(flush), .rk_idx(rk_idx),
    .rk_out(rk_out), .rk_avail(rk_avail), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---- reference model: S-box from GF(2^8) inverse + affine map ----
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented key expansion (w[0..43]), grouped four words per round key.
  function automatic sched_t expand_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Expected rk_out when round keys 0..last are valid.
  function automatic logic [127:0] exp_rk(input sched_t s, input int idx, input int last);
    if (idx <= 10 && idx <= last) return s[idx];
    return '0;
  endfunction

  // ---- monitor: on each done pulse pop the expected schedule and sweep ----
  initial begin
    sched_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("done_avail", rk_avail, 11'h7ff);
          mon_act = 1'b1;
          for (int r = 0; r <= 10; r++) begin
            mon_idx = 4'(r);
            #1;
            chk($sformatf("sb_rk%0d", r), rk_out, e[r]);
          end
          mon_act = 1'b0;
          @(negedge clk);
          chk("done_width", done, 1'b0);
        end
      end
    end
  end

  // Accept k, then follow E1..E10 checking status and a probed round key.
  task automatic run_exp(input logic [127:0] k, input int flush_at, input bit junk,
                         input bit hold, input logic [127:0] k2, input bit cc,
                         input logic [127:0] c1, input logic [127:0] c10);
    sched_t s;
    int     idx;
    s = expand_model(k);
    if (flush_at == 0) sbq.push_back(s);
    @(posedge clk); #1;
    key = k; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    idx = $urandom_range(0, 15);
    stim_idx = 4'(idx);
    #1;
    chk("e0_avail", rk_avail, 11'h001);
    chk("e0_busy", busy, 1'b1);
    chk("e0_ready", key_ready, 1'b0);
    chk("e0_rk", rk_out, exp_rk(s, idx, 0));
    for (int r = 1; r <= 10; r++) begin
      if (hold) begin
        key_valid = 1'b1; key = k2;
      end else if (junk) begin
        key_valid = 1'($urandom_range(0, 1));
        key = {$urandom, $urandom, $urandom, $urandom};
      end
      flush = (r == flush_at);
      @(posedge clk); #1;
      if (!hold) key_valid = 1'b0;
      flush = 1'b0;
      if (r == flush_at) begin
        #1;
        chk("fl_avail", rk_avail, 11'h000);
        chk("fl_busy", busy, 1'b0);
        chk("fl_ready", key_ready, 1'b1);
        chk("fl_done", done, 1'b0);
        for (int i = 0; i < 16; i++) begin
          stim_idx = 4'(i);
          #1;
          chk($sformatf("fl_rk%0d", i), rk_out, 128'h0);
        end
        return;
      end
      idx = $urandom_range(0, 15);
      if (cc && r == 1)  idx = 1;
      if (cc && r == 10) idx = 10;
      stim_idx = 4'(idx);
      #1;
      chk($sformatf("e%0d_avail", r), rk_avail, (128'h1 << (r + 1)) - 1);
      chk($sformatf("e%0d_busy", r), busy, r < 10);
      chk($sformatf("e%0d_ready", r), key_ready, r == 10);
      chk($sformatf("e%0d_done", r), done, r == 10);
      chk($sformatf("e%0d_rk%0d", r, idx), rk_out, exp_rk(s, idx, r));
      if (cc && r == 1)  chk("vec_rk1", rk_out, c1);
      if (cc && r == 10) chk("vec_rk10", rk_out, c10);
    end
  endtask

  initial begin
    logic [127:0] k2;
    int           fa;
    rst = 1'b1; key_valid = 1'b0; key = '0; flush = 1'b0; stim_idx = 4'd0;
    build_sbox();
    #5;
    chk("rst_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_avail", rk_avail, 11'h000);
    chk("rst_rk", rk_out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 example key
    run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 1'b0, '0, 1'b1,
            128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Out-of-range indices read zero in READY
    @(posedge clk); #2;
    for (int i = 11; i < 16; i++) begin
      stim_idx = 4'(i);
      #1;
      chk($sformatf("oor_rk%0d", i), rk_out, 128'h0);
    end

    // All-zero key
    run_exp(128'h0, 0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    stim_idx = 4'd1; #1;
    chk("zero_rk1", rk_out, 128'h62636363626363636263636362636363);
    stim_idx = 4'd10; #1;
    chk("zero_rk10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // key_valid held with a second key through EXPAND
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 1'b1, k2, 1'b1,
            128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sbq.push_back(expand_model(k2));
    @(posedge clk); #1;
    key_valid = 1'b0;
    #1;
    chk("k2_busy", busy, 1'b1);
    chk("k2_avail", rk_avail, 11'h001);
    chk("k2_ready", key_ready, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    chk("k2_e9_avail", rk_avail, 11'h3ff);
    chk("k2_e9_busy", busy, 1'b1);
    @(posedge clk); #2;
    chk("k2_e10_done", done, 1'b1);
    chk("k2_e10_busy", busy, 1'b0);

    // flush and key_valid at the same edge from READY
    @(posedge clk); #1;
    flush = 1'b1; key_valid = 1'b1; key = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    flush = 1'b0; key_valid = 1'b0;
    #1;
    chk("fkv_busy", busy, 1'b0);
    chk("fkv_ready", key_ready, 1'b1);
    chk("fkv_avail", rk_avail, 11'h000);
    @(posedge clk); #2;
    chk("fkv_busy2", busy, 1'b0);

    // flush at E5
    run_exp(128'h000102030405060708090a0b0c0d0e0f, 5, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    repeat (12) @(posedge clk);
    #2;
    chk("fl5_idle", busy, 1'b0);

    // asynchronous reset pulse between edges mid-expansion
    @(posedge clk); #1;
    key = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    stim_idx = 4'd0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_avail", rk_avail, 11'h000);
    chk("arst_ready", key_ready, 1'b1);
    chk("arst_rk0", rk_out, 128'h0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("arst_idle", busy, 1'b0);
    chk("arst_avail2", rk_avail, 11'h000);

    // randomized expansions with junk offers and occasional flushes
    for (int n = 0; n < 12; n++) begin
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      run_exp({$urandom, $urandom, $urandom, $urandom}, fa, 1'($urandom_range(0, 1)),
              1'b0, '0, 1'b0, '0, '0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 128'(sbq.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`: input, 1 bit; asynchronous, active-high reset.
REQ-003 SHALL have port `key_valid`: input, 1 bit; cipher key offered.
REQ-004 SHALL have port `key`: input, 128 bits; AES-128 cipher key; byte 0 = key[127:120].
REQ-005 SHALL have port `key_ready`: output, 1 bit; controller can accept a key.
REQ-006 SHALL have port `flush`: input, 1 bit; synchronous abort and invalidate.
REQ-007 SHALL have port `rk_idx`: input, 4 bits; round-key read index, 0..10.
REQ-008 SHALL have port `rk_out`: output, 128 bits; round key selected by rk_idx; combinational read.
REQ-009 SHALL have port `rk_avail`: output, 11 bits; bit r = 1 when round key r is stored and valid.
REQ-010 SHALL have port `busy`: output, 1 bit; expansion in progress.
REQ-011 SHALL have port `done`: output, 1 bit; one-cycle pulse when round key 10 is stored.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, EXPAND and READY.
REQ-013 SHALL drive key_ready=1 in IDLE and READY, and key_ready=0 in EXPAND.
REQ-014 SHALL accept a key on a rising edge where key_valid=1 and key_ready=1 (accept edge E0).
REQ-015 At E0, SHALL store key as round key 0, set rk_avail to 11'b1, set the round counter to 1, and enter EXPAND.
REQ-016 In EXPAND, SHALL compute and store one full 128-bit round key per cycle.
REQ-017 The round key for round r SHALL be produced at edge Er and SHALL set rk_avail[r] at that same edge.
REQ-018 Round key r SHALL be derived from round key r-1 (words w0..w3) as follows:
  - t = SubWord(RotWord(w3)) XOR Rcon[r], where RotWord rotates left by one byte;
  - new w0 = w0^t, new w1 = w1^new w0, new w2 = w2^new w1, new w3 = w3^new w2.
REQ-019 SubWord SHALL use four parallel FIPS-197 forward S-box instances.
REQ-020 Rcon[r] for r = 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 in the most significant byte, with the lower 24 bits zero.
REQ-021 At E10, SHALL enter READY and assert done for exactly the one cycle following E10.
REQ-022 Expansion latency SHALL be 10 cycles from acceptance to all 11 round keys being valid.
REQ-023 busy SHALL be 1 exactly while in EXPAND.
REQ-024 key_valid asserted while in EXPAND SHALL be ignored; no queuing or restart.
REQ-025 A key accepted in READY SHALL immediately begin a new expansion.
  - rk_avail SHALL become 11'b1 at the accept edge.
  - The old round keys 1..10 SHALL be marked invalid but may keep their stale contents unless KS_ZEROIZE_EN is defined.
REQ-026 rk_out SHALL equal the stored round key rk_idx whenever rk_avail[rk_idx]=1.
REQ-027 rk_out SHALL be all-zero when rk_avail[rk_idx]=0 or when rk_idx > 10.
REQ-028 flush=1 at a rising edge, in any state, SHALL force IDLE and rk_avail=0 and suppress done.
REQ-029 If flush and key_valid are both 1 at the same edge, flush SHALL win and the key SHALL not be accepted.
REQ-030 The round counter SHALL be 4 bits, SHALL count 1..10 and SHALL never wrap past 10.

Reset
REQ-031 While rst=1, SHALL hold the FSM in IDLE, the round counter at 0, rk_avail=0, busy=0 and done=0, regardless of clk.
REQ-032 As a consequence of REQ-031, key_ready SHALL be 1 and rk_out SHALL be zero during reset.
REQ-033 Reset asserted mid-expansion SHALL abandon the expansion, and no done pulse SHALL follow.
REQ-034 Round-key storage contents SHALL need no reset, because rk_avail gates all reads.

Configuration
REQ-035 When macro KS_ZEROIZE_EN is defined, all round-key storage SHALL clear to zero on rst, on flush, and on every key accept edge before round key 0 is written.
REQ-036 When KS_ZEROIZE_EN is undefined, storage SHALL be cleared by none of these events and SHALL only be overwritten by new round keys.
REQ-037 Port-visible behaviour of rk_out and rk_avail SHALL be identical with and without KS_ZEROIZE_EN.

Verification
REQ-038 Scenario 1: accept key 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_idx=1 after E1 SHALL give rk_out = a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 after E10 SHALL give rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done SHALL be high for exactly one cycle.
REQ-039 Scenario 2: accept an all-zero key; after E10, rk_idx=1 SHALL give 62636363626363636263636362636363 and rk_idx=10 SHALL give b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-040 Scenario 3: key_valid held high with a different key throughout EXPAND SHALL leave key_ready=0 and results identical to Scenario 1; the second key SHALL be accepted at the first edge in READY.
REQ-041 Scenario 4: flush at E5 SHALL give IDLE, rk_avail=0 and rk_out=0 for all indices, with no done pulse.
REQ-042 Scenario 5: async rst pulse between edges during EXPAND SHALL take effect immediately: busy=0, rk_avail=0, key_ready=1.
REQ-043 Scenario 6: rk_idx=11..15 in READY SHALL give rk_out=0; flush and key_valid at the same edge SHALL give IDLE with no accept.
